// File: rtl/spiker_reader.sv
// spiker_reader: input-side frame launcher for the spiker core.
//
// Software fills a shadow store of N_REG spike words. A start command copies
// the shadow store into a separate frame register, and the frame is presented
// to the core for N_STEPS valid/ready handshakes. The frame register is
// loaded only at launch, so shadow writes never disturb a frame in flight.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   test_mode_i           launch even when not every word has been written
//   reg_we_i/idx_i/data_i shadow word write port
//   start_i               launch request (pulse), honoured only in IDLE
//   clear_i               synchronous abort; clears shadow, mask and error
//   data_in_o/valid_o     spike vector and valid towards the core
//   ready_i               core accepts the current step
//   sample_o              one-cycle pulse per completed step
//   busy_o, done_o, err_o frame in flight, frame-complete pulse, sticky error
module spiker_reader #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_SPIKES   = 784,
    parameter int unsigned N_REG      = 25,
    parameter int unsigned DATA_WIDTH = 800,
    parameter int unsigned N_STEPS    = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_mode_i,
    input  logic                     reg_we_i,
    input  logic [$clog2(N_REG)-1:0] reg_idx_i,
    input  logic [WIDTH-1:0]         reg_data_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    output logic [DATA_WIDTH-1:0]    data_in_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     sample_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned CntW = $clog2(N_STEPS + 1);
    // Only the low N_SPIKES bits carry spikes; the padding bits are forced to 0.
    localparam logic [DATA_WIDTH-1:0] SpikeMask =
        (DATA_WIDTH'(1) << N_SPIKES) - DATA_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic [N_REG-1:0]        mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic                    sample_q, sample_d;
    logic                    idx_ok;

    assign idx_ok = 32'(reg_idx_i) < N_REG;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            err_q    <= err_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        data_d   = data_q;
        err_d    = err_q;
        sample_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if ((&mask_q) || test_mode_i) begin
                        // Launch copies the shadow as it was before any
                        // same-cycle write; that write is applied below.
                        data_d  = shadow_q & SpikeMask;
                        mask_d  = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (ready_i) begin
                    sample_d = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N_STEPS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reg_we_i) begin
            if (idx_ok) begin
                shadow_d[32'(reg_idx_i) * WIDTH +: WIDTH] = reg_data_i;
                mask_d[reg_idx_i]                          = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Abort overrides everything; the frame register keeps its last value.
        if (clear_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            shadow_d = '0;
            mask_d   = '0;
            err_d    = 1'b0;
            sample_d = 1'b0;
        end
    end

    assign data_in_o = data_q;
    assign valid_o   = (state_q == StRun);
    assign busy_o    = (state_q == StRun);
    assign done_o    = (state_q == StDone);
    assign sample_o  = sample_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_spiker_reader.sv
// Directed bench for spiker_reader. Inputs change 1 time unit after the rising
// edge; outputs are observed at that same point, i.e. after each edge settles.
module tb_spiker_reader;

    localparam int NR = 25;
    localparam int DW = 800;
    localparam int NS = 15;

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          test_mode_i = 1'b0;
    logic          reg_we_i    = 1'b0;
    logic [4:0]    reg_idx_i   = '0;
    logic [31:0]   reg_data_i  = '0;
    logic          start_i     = 1'b0;
    logic          clear_i     = 1'b0;
    logic          ready_i     = 1'b0;
    logic [DW-1:0] data_in_o;
    logic          valid_o, sample_o, busy_o, done_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame observations filled in by drive_frame.
    int         n_hs, n_smp, n_done, done_cyc, last_hs;
    bit         stable, smp_ok, vld_ok;
    logic [1:0] vb_clr;

    spiker_reader dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .test_mode_i(test_mode_i),
        .reg_we_i   (reg_we_i),
        .reg_idx_i  (reg_idx_i),
        .reg_data_i (reg_data_i),
        .start_i    (start_i),
        .clear_i    (clear_i),
        .data_in_o  (data_in_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sample_o   (sample_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] d);
        reg_we_i   = 1'b1;
        reg_idx_i  = 5'(idx);
        reg_data_i = d;
        tick();
        reg_we_i = 1'b0;
    endtask

    task automatic write_range(input int lo, input int hi, input logic [31:0] base);
        for (int k = lo; k <= hi; k++) write_word(k, base + 32'(k));
    endtask

    task automatic launch();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // Runs 70 cycles after a launch. ready_i is high every period-th cycle; the
    // bench's own model of valid (high until NS handshakes or an abort) decides
    // which edges are handshakes and therefore where sample_o must pulse.
    task automatic drive_frame(input int period, input int rewrite_cyc, input int clear_hs);
        logic [DW-1:0] first;
        bit exp_valid, hs_now, clr_now, cleared;
        first = data_in_o;
        n_hs = 0; n_smp = 0; n_done = 0; done_cyc = -1; last_hs = -1;
        stable = 1; smp_ok = 1; vld_ok = 1; vb_clr = 2'b11; cleared = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            exp_valid = !cleared && (n_hs < NS);
            ready_i   = (cyc % period == 0);
            clr_now   = (clear_hs >= 0) && !cleared && (n_hs == clear_hs);
            clear_i   = clr_now;
            if (cyc == rewrite_cyc) begin
                reg_we_i   = 1'b1;
                reg_idx_i  = 5'd0;
                reg_data_i = 32'hFFFF_FFFF;
            end
            hs_now = exp_valid && ready_i && !clr_now;
            tick();
            clear_i  = 1'b0;
            reg_we_i = 1'b0;
            if (clr_now) begin
                cleared = 1;
                vb_clr  = {valid_o, busy_o};
            end
            if (hs_now) begin
                n_hs++;
                last_hs = cyc;
            end
            exp_valid = !cleared && (n_hs < NS);
            if ({valid_o, busy_o} !== {exp_valid, exp_valid}) vld_ok = 0;
            if (sample_o !== hs_now) smp_ok = 0;
            if (sample_o === 1'b1) n_smp++;
            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (data_in_o !== first) stable = 0;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_checks++; if ({valid_o, busy_o, done_o, sample_o, err_o} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {valid_o, busy_o, done_o, sample_o, err_o}); end
        n_checks++; if (data_in_o !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero want 0"); end
        rst_ni = 1'b1;
        tick();
        n_checks++; if ({valid_o, busy_o, done_o, sample_o, err_o} !== 5'b0) begin n_fail++; $display("FAIL post_reset_ctrl: got %b want 00000", {valid_o, busy_o, done_o, sample_o, err_o}); end
    endtask

    task automatic test_full_frame();
        write_range(0, 24, 32'h0000_0100);
        ready_i = 1'b1;
        launch();
        n_checks++; if ({valid_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL full_launch: valid/busy got %b want 11", {valid_o, busy_o}); end
        n_checks++; if (data_in_o[31:0] !== 32'h100) begin n_fail++; $display("FAIL full_word0: got %h want 00000100", data_in_o[31:0]); end
        n_checks++; if (data_in_o[783:768] !== 16'h0118) begin n_fail++; $display("FAIL full_word24: got %h want 0118", data_in_o[783:768]); end
        n_checks++; if (data_in_o[799:784] !== 16'h0) begin n_fail++; $display("FAIL full_pad: got %h want 0000", data_in_o[799:784]); end
        drive_frame(1, -1, -1);
        n_checks++; if (n_smp !== NS) begin n_fail++; $display("FAIL full_samples: got %0d want %0d", n_smp, NS); end
        n_checks++; if (n_done !== 1 || done_cyc !== 15) begin n_fail++; $display("FAIL full_done: got %0d pulses at cyc %0d want 1 at 15", n_done, done_cyc); end
        n_checks++; if (!smp_ok || !vld_ok || !stable) begin n_fail++; $display("FAIL full_seq: smp_ok %0d vld_ok %0d stable %0d want 1 1 1", smp_ok, vld_ok, stable); end
        n_checks++; if ({busy_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL full_end: busy/err got %b want 00", {busy_o, err_o}); end
    endtask

    task automatic test_backpressure();
        write_range(0, 24, 32'h0000_0200);
        launch();
        n_checks++; if (data_in_o[31:0] !== 32'h200) begin n_fail++; $display("FAIL bp_word0: got %h want 00000200", data_in_o[31:0]); end
        drive_frame(3, -1, -1);
        n_checks++; if (n_smp !== NS || n_hs !== NS) begin n_fail++; $display("FAIL bp_samples: got %0d want %0d", n_smp, NS); end
        n_checks++; if (n_done !== 1 || done_cyc !== 45 || done_cyc !== last_hs) begin n_fail++; $display("FAIL bp_done: got %0d pulses at cyc %0d want 1 at 45", n_done, done_cyc); end
        n_checks++; if (!smp_ok || !vld_ok || !stable) begin n_fail++; $display("FAIL bp_seq: smp_ok %0d vld_ok %0d stable %0d want 1 1 1", smp_ok, vld_ok, stable); end
    endtask

    task automatic test_incomplete();
        pulse_clear();
        write_range(0, 23, 32'h0000_0300);
        launch();
        n_checks++; if ({valid_o, busy_o, err_o} !== 3'b001) begin n_fail++; $display("FAIL inc_reject: valid/busy/err got %b want 001", {valid_o, busy_o, err_o}); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL inc_idle: valid got %b want 0", valid_o); end
        test_mode_i = 1'b1;
        launch();
        test_mode_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || data_in_o[31:0] !== 32'h300) begin n_fail++; $display("FAIL tm_launch: valid %b word0 %h want 1 00000300", valid_o, data_in_o[31:0]); end
        n_checks++; if (data_in_o[799:768] !== 32'h0) begin n_fail++; $display("FAIL tm_missing: got %h want 00000000", data_in_o[799:768]); end
        drive_frame(1, -1, -1);
        n_checks++; if (n_smp !== NS || n_done !== 1) begin n_fail++; $display("FAIL tm_frame: samples %0d done %0d want %0d 1", n_smp, n_done, NS); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_rewrite_and_same_cycle();
        write_range(0, 24, 32'h0000_0400);
        launch();
        n_checks++; if (data_in_o[31:0] !== 32'h400) begin n_fail++; $display("FAIL rw_word0: got %h want 00000400", data_in_o[31:0]); end
        drive_frame(1, 3, -1);
        n_checks++; if (!stable || n_done !== 1) begin n_fail++; $display("FAIL rw_stable: stable %0d done %0d want 1 1", stable, n_done); end
        write_range(1, 23, 32'h0000_0400);
        write_word(24, 32'hFFFF_FFFF);
        // Launch and write word 5 in the same cycle.
        start_i    = 1'b1;
        reg_we_i   = 1'b1;
        reg_idx_i  = 5'd5;
        reg_data_i = 32'hABCD_0005;
        tick();
        start_i  = 1'b0;
        reg_we_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || data_in_o[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rw_next: valid %b word0 %h want 1 ffffffff", valid_o, data_in_o[31:0]); end
        n_checks++; if (data_in_o[191:160] !== 32'h405) begin n_fail++; $display("FAIL sc_preload: got %h want 00000405", data_in_o[191:160]); end
        n_checks++; if (data_in_o[799:768] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL pad_mask: got %h want 0000ffff", data_in_o[799:768]); end
        drive_frame(1, -1, -1);
        write_range(0, 4, 32'h0000_0600);
        write_range(6, 24, 32'h0000_0600);
        launch();
        n_checks++; if (valid_o !== 1'b1 || data_in_o[191:160] !== 32'hABCD_0005) begin n_fail++; $display("FAIL sc_mask_kept: valid %b word5 %h want 1 abcd0005", valid_o, data_in_o[191:160]); end
        drive_frame(1, -1, -1);
    endtask

    task automatic test_clear();
        pulse_clear();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b want 0", err_o); end
        write_range(0, 24, 32'h0000_0500);
        launch();
        drive_frame(1, -1, 7);
        n_checks++; if (vb_clr !== 2'b00) begin n_fail++; $display("FAIL clr_vb: got %b want 00", vb_clr); end
        n_checks++; if (n_smp !== 7 || n_done !== 0) begin n_fail++; $display("FAIL clr_pulses: samples %0d done %0d want 7 0", n_smp, n_done); end
        n_checks++; if (!stable || !vld_ok || !smp_ok || data_in_o[31:0] !== 32'h500) begin n_fail++; $display("FAIL clr_hold: stable %0d vld_ok %0d smp_ok %0d word0 %h want 1 1 1 00000500", stable, vld_ok, smp_ok, data_in_o[31:0]); end
        launch();
        n_checks++; if ({valid_o, err_o} !== 2'b01) begin n_fail++; $display("FAIL clr_mask: valid/err got %b want 01", {valid_o, err_o}); end
    endtask

    task automatic test_bad_idx_and_reset();
        pulse_clear();
        write_word(27, 32'hDEAD_BEEF);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL bad_idx: err got %b want 1", err_o); end
        write_range(0, 24, 32'h0000_0700);
        launch();
        tick();
        tick();
        n_checks++; if ({valid_o, busy_o, err_o} !== 3'b111) begin n_fail++; $display("FAIL rst_pre: valid/busy/err got %b want 111", {valid_o, busy_o, err_o}); end
        rst_ni = 1'b0;
        #1;
        n_checks++; if ({valid_o, busy_o, done_o, sample_o, err_o} !== 5'b0 || data_in_o !== '0) begin n_fail++; $display("FAIL rst_mid: ctrl %b want 00000, data nonzero %0d", {valid_o, busy_o, done_o, sample_o, err_o}, data_in_o != '0); end
        tick();
        rst_ni = 1'b1;
        tick();
        n_checks++; if ({valid_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL rst_after: valid/done got %b want 00", {valid_o, done_o}); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_incomplete();
        test_rewrite_and_same_cycle();
        test_clear();
        test_bad_idx_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
